ls_queue: RTL and testbench

- In-order load/store buffer of the Tomasulo core. Receives memory ops from the issue stage (CU plus RegFile operand read).
- Snoops the CDB broadcast to resolve pending operands, then issues the head op to data memory.
- Load results go back onto the CDB through the require/requireAC handshake, as CDBHelper source 3 (ls).
- Occupies ResStationEN[3] and the isFull[3] slot.

---
 rtl/ls_queue_pkg.sv | 25 ++
 rtl/ls_entry.sv | 70 +++++++
 rtl/ls_queue.sv | 154 +++++++++++++++
 tb/tb_ls_queue.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ls_queue_pkg.sv
// ls_queue_pkg: shared op encodings, tag constants and head FSM states for the load/store queue
package ls_queue_pkg;

    localparam int LABEL_W = 4;
    localparam logic [LABEL_W-1:0] LABEL_NONE = '0;

    localparam logic LS_LOAD  = 1'b0;
    localparam logic LS_STORE = 1'b1;

    typedef enum logic [1:0] {
        WAIT,
        MEM,
        CDB
    } head_state_t;

    // A broadcast matches a tag only when it is live and the tag names a producer.
    function automatic logic tag_hit(
        input logic               en,
        input logic [LABEL_W-1:0] bc_label,
        input logic [LABEL_W-1:0] tag
    );
        return en && tag != LABEL_NONE && bc_label == tag;
    endfunction

endpackage

// File: rtl/ls_entry.sv
// ls_entry: one queue slot holding a memory op, resolving its operands from the CDB
module ls_entry
    import ls_queue_pkg::*;
#(
    parameter int AW = 32
)(
    input  logic               clk,
    input  logic               nRST,
    input  logic               wr,
    input  logic               free,
    input  logic               op_in,
    input  logic [AW-1:0]      vj_in,
    input  logic [LABEL_W-1:0] qj_in,
    input  logic [AW-1:0]      vk_in,
    input  logic [LABEL_W-1:0] qk_in,
    input  logic [15:0]        off_in,
    input  logic               bc_en,
    input  logic [LABEL_W-1:0] bc_label,
    input  logic [AW-1:0]      bc_data,
    output logic               valid,
    output logic               op,
    output logic [AW-1:0]      vj,
    output logic [LABEL_W-1:0] qj,
    output logic [AW-1:0]      vk,
    output logic [LABEL_W-1:0] qk,
    output logic [15:0]        off
);

    logic fwd_j, fwd_k, snp_j, snp_k;

    // Broadcast matches against incoming operands (forward) and stored ones (snoop).
    always_comb begin
        fwd_j = tag_hit(bc_en, bc_label, qj_in);
        fwd_k = tag_hit(bc_en, bc_label, qk_in);
        snp_j = valid && tag_hit(bc_en, bc_label, qj);
        snp_k = valid && tag_hit(bc_en, bc_label, qk);
    end

    // Slot storage: load on write with same-cycle forwarding, otherwise snoop and free.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            valid <= 1'b0;
            op    <= LS_LOAD;
            vj    <= '0;
            qj    <= LABEL_NONE;
            vk    <= '0;
            qk    <= LABEL_NONE;
            off   <= '0;
        end else if (wr) begin
            valid <= 1'b1;
            op    <= op_in;
            off   <= off_in;
            vj    <= fwd_j ? bc_data : vj_in;
            qj    <= fwd_j ? LABEL_NONE : qj_in;
            vk    <= fwd_k ? bc_data : vk_in;
            qk    <= fwd_k ? LABEL_NONE : qk_in;
        end else begin
            if (free) valid <= 1'b0;
            if (snp_j) begin
                vj <= bc_data;
                qj <= LABEL_NONE;
            end
            if (snp_k) begin
                vk <= bc_data;
                qk <= LABEL_NONE;
            end
        end
    end

endmodule

// File: rtl/ls_queue.sv
// ls_queue: in-order load/store queue with CDB snoop; define LSQ_PERF_EN for perfLoads/perfStalls counters
module ls_queue
    import ls_queue_pkg::*;
#(
    parameter int                 DEPTH      = 4,
    parameter logic [LABEL_W-1:0] LABEL_BASE = 4'd12,
    parameter int                 AW         = 32
)(
    input  logic               clk,
    input  logic               nRST,
    input  logic               WEN,
    input  logic               opIn,
    input  logic [AW-1:0]      dataIn1,
    input  logic [LABEL_W-1:0] label1,
    input  logic [AW-1:0]      dataIn2,
    input  logic [LABEL_W-1:0] label2,
    input  logic [15:0]        offset,
    output logic               isFull,
    output logic [LABEL_W-1:0] labelOut,
    input  logic               BCEN,
    input  logic [LABEL_W-1:0] BClabel,
    input  logic [AW-1:0]      BCdata,
    output logic               memReq,
    output logic               memWrite,
    output logic [AW-1:0]      memAddr,
    output logic [AW-1:0]      memWData,
    input  logic               memAck,
    input  logic [AW-1:0]      memRData,
    output logic               require,
    input  logic               requireAC,
    output logic [AW-1:0]      resultData,
    output logic [LABEL_W-1:0] resultLabel
`ifdef LSQ_PERF_EN
    ,
    output logic [15:0]        perfLoads,
    output logic [15:0]        perfStalls
`endif
);

    localparam int PW = $clog2(DEPTH);

    head_state_t st, nxt;
    logic [PW-1:0] head, tail;
    logic enq, pop, in_rdy, head_rdy, go;

    logic               e_valid [DEPTH];
    logic               e_op    [DEPTH];
    logic [AW-1:0]      e_vj    [DEPTH];
    logic [LABEL_W-1:0] e_qj    [DEPTH];
    logic [AW-1:0]      e_vk    [DEPTH];
    logic [LABEL_W-1:0] e_qk    [DEPTH];
    logic [15:0]        e_off   [DEPTH];

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        ls_entry #(.AW(AW)) u_ent (
            .clk      (clk),
            .nRST     (nRST),
            .wr       (enq && tail == PW'(i)),
            .free     (pop && head == PW'(i)),
            .op_in    (opIn),
            .vj_in    (dataIn1),
            .qj_in    (label1),
            .vk_in    (dataIn2),
            .qk_in    (label2),
            .off_in   (offset),
            .bc_en    (BCEN),
            .bc_label (BClabel),
            .bc_data  (BCdata),
            .valid    (e_valid[i]),
            .op       (e_op[i]),
            .vj       (e_vj[i]),
            .qj       (e_qj[i]),
            .vk       (e_vk[i]),
            .qk       (e_qk[i]),
            .off      (e_off[i])
        );
    end

    // Occupancy and readiness: the queue is full when the tail slot is still held;
    // an empty queue lets a resolved incoming op start its access on the enqueue edge.
    always_comb begin
        isFull   = e_valid[tail];
        labelOut = LABEL_BASE + LABEL_W'(tail);
        enq      = WEN && !isFull;
        in_rdy   = (label1 == LABEL_NONE || tag_hit(BCEN, BClabel, label1)) &&
                   (opIn == LS_LOAD || label2 == LABEL_NONE || tag_hit(BCEN, BClabel, label2));
        head_rdy = e_qj[head] == LABEL_NONE && (e_op[head] == LS_LOAD || e_qk[head] == LABEL_NONE);
        go       = e_valid[head] ? head_rdy : enq && in_rdy;
    end

    // Head FSM next state, head release and memory/CDB request outputs.
    always_comb begin
        nxt      = st;
        pop      = 1'b0;
        memReq   = st == MEM;
        require  = st == CDB;
        memWrite = e_op[head];
        memAddr  = e_vj[head] + {{(AW-16){e_off[head][15]}}, e_off[head]};
        memWData = e_vk[head];
        case (st)
            WAIT: if (go) nxt = MEM;
            MEM: if (memAck) begin
                nxt = e_op[head] == LS_STORE ? WAIT : CDB;
                pop = e_op[head] == LS_STORE;
            end
            default: if (requireAC) begin
                nxt = WAIT;
                pop = 1'b1;
            end
        endcase
    end

    // Head FSM state register.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) st <= WAIT;
        else       st <= nxt;
    end

    // Ring pointers advance on enqueue and on head release.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (enq) tail <= tail + 1'b1;
            if (pop) head <= head + 1'b1;
        end
    end

    // Load result captured when memory answers, held for the CDB handshake.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            resultData  <= '0;
            resultLabel <= LABEL_NONE;
        end else if (st == MEM && memAck && e_op[head] == LS_LOAD) begin
            resultData  <= memRData;
            resultLabel <= LABEL_BASE + LABEL_W'(head);
        end
    end

`ifdef LSQ_PERF_EN
    // Wrapping counters of CDB grants and of issue attempts refused while full.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            perfLoads  <= '0;
            perfStalls <= '0;
        end else begin
            if (st == CDB && requireAC) perfLoads <= perfLoads + 1'b1;
            if (WEN && isFull) perfStalls <= perfStalls + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ls_queue.sv
// tb_ls_queue: randomized self-checking bench for ls_queue against a queue-based reference model
module tb_ls_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        WEN = 1'b0, opIn = 1'b0;
    logic [31:0] dataIn1 = '0, dataIn2 = '0;
    logic [3:0]  label1 = '0, label2 = '0;
    logic [15:0] offset = '0;
    logic        isFull;
    logic [3:0]  labelOut;
    logic        BCEN = 1'b0;
    logic [3:0]  BClabel = '0;
    logic [31:0] BCdata = '0;
    logic        memReq, memWrite;
    logic [31:0] memAddr, memWData;
    logic        memAck = 1'b0;
    logic [31:0] memRData = '0;
    logic        require;
    logic        requireAC = 1'b0;
    logic [31:0] resultData;
    logic [3:0]  resultLabel;
`ifdef LSQ_PERF_EN
    logic [15:0] perfLoads, perfStalls;
`endif

    always #5 clk = ~clk;

    ls_queue dut (
        .clk(clk), .nRST(nRST), .WEN(WEN), .opIn(opIn),
        .dataIn1(dataIn1), .label1(label1), .dataIn2(dataIn2), .label2(label2),
        .offset(offset), .isFull(isFull), .labelOut(labelOut),
        .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata),
        .memReq(memReq), .memWrite(memWrite), .memAddr(memAddr), .memWData(memWData),
        .memAck(memAck), .memRData(memRData),
        .require(require), .requireAC(requireAC),
        .resultData(resultData), .resultLabel(resultLabel)
`ifdef LSQ_PERF_EN
        , .perfLoads(perfLoads), .perfStalls(perfStalls)
`endif
    );

    typedef struct {
        logic        op;
        logic [31:0] vj;
        logic [3:0]  qj;
        logic [31:0] vk;
        logic [3:0]  qk;
        logic [15:0] off;
        logic [3:0]  tag;
    } ent_t;

    ent_t        q[$];
    bit          m_mem, m_cdb;
    int          tail_m;
    logic [31:0] exp_rd;
    logic [3:0]  exp_rl;
    int          m_loads, m_stalls;
    int          tests = 0, fails = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit rdy(input ent_t e);
        return e.qj == 0 && (e.op == 1'b0 || e.qk == 0);
    endfunction

    function automatic logic [31:0] addr_of(input ent_t e);
        return e.vj + {{16{e.off[15]}}, e.off};
    endfunction

    task automatic model_clear();
        q.delete();
        m_mem = 0; m_cdb = 0; tail_m = 0;
        exp_rd = '0; exp_rl = '0;
        m_loads = 0; m_stalls = 0;
    endtask

    task automatic check_outputs();
        check("isFull", {31'b0, isFull}, {31'b0, q.size() == DEPTH});
        if (q.size() < DEPTH) check("labelOut", {28'b0, labelOut}, 32'(12 + tail_m));
        check("memReq", {31'b0, memReq}, {31'b0, m_mem});
        if (m_mem) begin
            check("memWrite", {31'b0, memWrite}, {31'b0, q[0].op});
            check("memAddr", memAddr, addr_of(q[0]));
            if (q[0].op) check("memWData", memWData, q[0].vk);
        end
        check("require", {31'b0, require}, {31'b0, m_cdb});
        if (m_cdb) begin
            check("resultData", resultData, exp_rd);
            check("resultLabel", {28'b0, resultLabel}, {28'b0, exp_rl});
        end
    endtask

    // Reference update for one clock edge using the inputs just driven.
    task automatic model_edge();
        ent_t n;
        bit full_pre, enq, start;
        full_pre = q.size() == DEPTH;
        enq = WEN && !full_pre;
        n.op  = opIn;
        n.off = offset;
        n.tag = 4'(12 + tail_m);
        n.vj  = (BCEN && label1 != 0 && BClabel == label1) ? BCdata : dataIn1;
        n.qj  = (BCEN && label1 != 0 && BClabel == label1) ? 4'd0 : label1;
        n.vk  = (BCEN && label2 != 0 && BClabel == label2) ? BCdata : dataIn2;
        n.qk  = (BCEN && label2 != 0 && BClabel == label2) ? 4'd0 : label2;
        start = !m_mem && !m_cdb && (q.size() != 0 ? rdy(q[0]) : (enq && rdy(n)));
        if (WEN && full_pre) m_stalls++;
        if (BCEN && BClabel != 0)
            foreach (q[i]) begin
                if (q[i].qj == BClabel) begin q[i].vj = BCdata; q[i].qj = 0; end
                if (q[i].qk == BClabel) begin q[i].vk = BCdata; q[i].qk = 0; end
            end
        if (m_mem && memAck) begin
            if (q[0].op) void'(q.pop_front());
            else begin
                exp_rd = memRData;
                exp_rl = q[0].tag;
                m_cdb = 1;
            end
            m_mem = 0;
        end else if (m_cdb && requireAC) begin
            void'(q.pop_front());
            m_cdb = 0;
            m_loads++;
        end
        if (enq) begin
            q.push_back(n);
            tail_m = (tail_m + 1) % DEPTH;
        end
        if (start) m_mem = 1;
    endtask

    task automatic cyc(input bit w, input bit o, input logic [31:0] d1, input logic [3:0] l1,
                       input logic [31:0] d2, input logic [3:0] l2, input logic [15:0] off,
                       input bit bce, input logic [3:0] bcl, input logic [31:0] bcd,
                       input bit ack, input logic [31:0] rd, input bit ac);
        @(negedge clk);
        check_outputs();
        WEN = w; opIn = o; dataIn1 = d1; label1 = l1; dataIn2 = d2; label2 = l2; offset = off;
        BCEN = bce; BClabel = bcl; BCdata = bcd;
        memAck = ack && m_mem; memRData = rd;
        requireAC = ac && m_cdb;
        model_edge();
    endtask

    task automatic idle();                   cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0); endtask
    task automatic bc(input logic [3:0] l, input logic [31:0] d); cyc(0, 0, 0, 0, 0, 0, 0, 1, l, d, 0, 0, 0); endtask
    task automatic ack(input logic [31:0] rd); cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, rd, 0); endtask
    task automatic grant();                  cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1); endtask
    task automatic enq(input bit o, input logic [31:0] d1, input logic [3:0] l1,
                       input logic [31:0] d2, input logic [3:0] l2, input logic [15:0] off);
        cyc(1, o, d1, l1, d2, l2, off, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        nRST = 0;
        WEN = 0; BCEN = 0; memAck = 0; requireAC = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst isFull", {31'b0, isFull}, 0);
        check("rst labelOut", {28'b0, labelOut}, 12);
        check("rst memReq", {31'b0, memReq}, 0);
        check("rst require", {31'b0, require}, 0);
        check("rst resultData", resultData, 0);
        check("rst resultLabel", {28'b0, resultLabel}, 0);
`ifdef LSQ_PERF_EN
        check("rst perfLoads", {16'b0, perfLoads}, 0);
        check("rst perfStalls", {16'b0, perfStalls}, 0);
`endif
        nRST = 1;
        model_clear();
    endtask

    function automatic logic [3:0] rnd_label();
        return $urandom_range(0, 1) != 0 ? 4'd0 : 4'($urandom_range(1, 11));
    endfunction

    initial begin
        model_clear();
        do_reset();

        // load with negative offset, memory answer, CDB handshake
        enq(0, 32'h100, 0, 0, 0, 16'hFFFC);
        idle();
        check("t1 memReq", {31'b0, memReq}, 1);
        check("t1 memAddr", memAddr, 32'hFC);
        check("t1 memWrite", {31'b0, memWrite}, 0);
        ack(32'hDEAD);
        idle();
        check("t1 require", {31'b0, require}, 1);
        check("t1 resultLabel", {28'b0, resultLabel}, 12);
        check("t1 resultData", resultData, 32'hDEAD);
        grant();
        idle();
        check("t1 require drop", {31'b0, require}, 0);

        // store waiting on its data operand
        enq(1, 32'h40, 0, 32'h999, 5, 16'd4);
        idle();
        bc(5, 32'h1234);
        idle();
        idle();
        check("t2 memReq", {31'b0, memReq}, 1);
        check("t2 memAddr", memAddr, 32'h44);
        check("t2 memWData", memWData, 32'h1234);
        check("t2 memWrite", {31'b0, memWrite}, 1);
        ack(0);
        idle();
        check("t2 no require", {31'b0, require}, 0);

        // base operand forwarded from the CDB in the enqueue cycle
        cyc(1, 0, 32'hAAAA, 7, 0, 0, 16'd8, 1, 7, 32'h55, 0, 0, 0);
        idle();
        check("t3 memReq", {31'b0, memReq}, 1);
        check("t3 memAddr", memAddr, 32'h5D);
        ack(32'h77);
        grant();
        idle();

        // reset while a memory request is outstanding
        enq(0, 32'h200, 0, 0, 0, 16'd0);
        idle();
        check("t4 memReq pre", {31'b0, memReq}, 1);
        #2 nRST = 0;
        #1 check("t4 memReq async", {31'b0, memReq}, 0);
        check("t4 require async", {31'b0, require}, 0);
        check("t4 isFull async", {31'b0, isFull}, 0);
        do_reset();

        // fill with a blocked head, refused issues, then release
        enq(0, 0, 9, 0, 0, 0);
        repeat (3) enq(0, 0, 10, 0, 0, 0);
        idle();
        check("t5 isFull", {31'b0, isFull}, 1);
        enq(0, 32'h77, 0, 0, 0, 0);
        enq(0, 32'h78, 0, 0, 0, 0);
        idle();
        check("t5 isFull hold", {31'b0, isFull}, 1);
        check("t5 labelOut wrap", {28'b0, labelOut}, 12);
        bc(9, 32'h10);
        idle();
        ack(32'h3);
        grant();
        idle();
        check("t5 isFull freed", {31'b0, isFull}, 0);
        check("t5 labelOut free", {28'b0, labelOut}, 12);
`ifdef LSQ_PERF_EN
        check("t5 perfLoads", {16'b0, perfLoads}, 1);
        check("t5 perfStalls", {16'b0, perfStalls}, 2);
`endif
        enq(1, 32'h5, 0, 32'h6, 0, 0);

        // randomized traffic against the reference model
        repeat (3000)
            cyc($urandom_range(0, 1) != 0, $urandom_range(0, 1) != 0, $urandom, rnd_label(),
                $urandom, rnd_label(), 16'($urandom),
                $urandom_range(0, 9) < 4, 4'($urandom_range(0, 11)), $urandom,
                $urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 9) < 4);
        @(negedge clk);
        check_outputs();
`ifdef LSQ_PERF_EN
        check("perfLoads", {16'b0, perfLoads}, {16'b0, 16'(m_loads)});
        check("perfStalls", {16'b0, perfStalls}, {16'b0, 16'(m_stalls)});
`endif

        // reset while waiting for the CDB grant
        do_reset();
        enq(0, 32'h300, 0, 0, 0, 16'd0);
        idle();
        ack(32'hBEEF);
        idle();
        check("t6 require pre", {31'b0, require}, 1);
        #2 nRST = 0;
        #1 check("t6 require async", {31'b0, require}, 0);
        do_reset();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
